multicycle_control_fsm: RTL and testbench

- Moore-style multicycle control unit; consumes the 4-bit opcode held in small_reg_component and drives every register write enable and datapath select in the processor.
- Owns the opcode register's write strobe (opcode_write), so it sits directly downstream of that register and also feeds it.
- Sequences fetch/decode/execute/memory/writeback and counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// multicycle_control_fsm
//   Moore multicycle control unit: sequences fetch/decode/execute/memory/
//   writeback from the registered opcode and counts retired instructions.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             opcode,
    input  logic                   zero,
    input  logic                   stall,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   opcode_write,
    output logic                   ab_write,
    output logic                   alu_out_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic                   mem_to_reg,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic [3:0]             state,
    output logic                   halted,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] EXEC_R    = 4'd2;
    localparam logic [3:0] EXEC_I    = 4'd3;
    localparam logic [3:0] MEM_ADDR  = 4'd4;
    localparam logic [3:0] MEM_READ  = 4'd5;
    localparam logic [3:0] MEM_WRITE = 4'd6;
    localparam logic [3:0] WB        = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] JUMP      = 4'd9;
    localparam logic [3:0] HALT      = 4'd10;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0] next_state;
    logic       retire;
    logic       opcode_legal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                instr_count <= instr_count + COUNT_ONE;
            end
        end
    end

    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_NOP, OP_ADD, OP_ADDI, OP_LW,
            OP_SW, OP_BEQ, OP_JMP, OP_HALT: opcode_legal = 1'b1;
            default:                        opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        if (state == HALT) begin
            next_state = HALT;
        end else if (!stall) begin
            case (state)
                FETCH:  next_state = DECODE;
                DECODE: begin
                    case (opcode)
                        OP_ADD:  next_state = EXEC_R;
                        OP_ADDI: next_state = EXEC_I;
                        OP_LW,
                        OP_SW:   next_state = MEM_ADDR;
                        OP_BEQ:  next_state = BRANCH;
                        OP_JMP:  next_state = JUMP;
                        OP_HALT: next_state = HALT;
                        default: next_state = FETCH;
                    endcase
                    retire = (opcode == OP_NOP);
                end
                EXEC_R, EXEC_I: next_state = WB;
                MEM_ADDR:  next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
                MEM_READ:  next_state = WB;
                WB, MEM_WRITE, BRANCH, JUMP: begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end
                default:   next_state = FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        opcode_write  = 1'b0;
        ab_write      = 1'b0;
        alu_out_write = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halted        = 1'b0;
        illegal       = 1'b0;
        case (state)
            FETCH: begin
                mem_read     = 1'b1;
                ir_write     = 1'b1;
                opcode_write = 1'b1;
                pc_write     = 1'b1;
                alu_src_b    = 2'b01;
            end
            DECODE: begin
                ab_write      = 1'b1;
                alu_out_write = 1'b1;
                alu_src_b     = 2'b10;
                illegal       = !opcode_legal;
            end
            EXEC_R: begin
                alu_out_write = 1'b1;
                alu_op        = 2'b10;
            end
            EXEC_I, MEM_ADDR: begin
                alu_out_write = 1'b1;
                alu_src_b     = 2'b10;
            end
            MEM_READ:  mem_read  = 1'b1;
            MEM_WRITE: mem_write = 1'b1;
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LW);
            end
            BRANCH: begin
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = zero;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase

        // Stall freezes the machine: strobes drop but selects keep their decode.
        if (stall) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            opcode_write  = 1'b0;
            ab_write      = 1'b0;
            alu_out_write = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            illegal       = 1'b0;
        end

        if (!reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            opcode_write  = 1'b0;
            ab_write      = 1'b0;
            alu_out_write = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            halted        = 1'b0;
            illegal       = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// tb_multicycle_control_fsm
//   Directed self-checking bench for the multicycle control FSM.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       stall;
    logic       pc_write, ir_write, opcode_write, ab_write, alu_out_write;
    logic       mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       halted, illegal;
    logic [7:0] instr_count;

    int checks = 0;
    int errors = 0;

    multicycle_control_fsm #(.COUNT_WIDTH(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .stall         (stall),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .opcode_write  (opcode_write),
        .ab_write      (ab_write),
        .alu_out_write (alu_out_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .halted        (halted),
        .illegal       (illegal),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction from FETCH; seq lists the states expected after each edge.
    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic [23:0] seq, input int n);
        logic [3:0] s;
        opcode = op;
        check({name, "_start"}, 32'(state), 32'd0);
        for (int i = 0; i < n; i++) begin
            s = seq[4*(n-1-i) +: 4];
            tick();
            check({name, "_state"}, 32'(state), 32'(s));
            check({name, "_reg_write"}, 32'(reg_write), 32'(s == 4'd7));
            check({name, "_mem_write"}, 32'(mem_write), 32'(s == 4'd6));
            check({name, "_mem_read"}, 32'(mem_read), 32'(s == 4'd0 || s == 4'd5));
            check({name, "_mem_to_reg"}, 32'(mem_to_reg), 32'(s == 4'd7 && op == 4'b0011));
            if (s == 4'd8) begin
                check({name, "_br_pc_write"}, 32'(pc_write), 32'(zero));
                check({name, "_br_pc_source"}, 32'(pc_source), 32'd1);
            end
            if (s == 4'd9) begin
                check({name, "_j_pc_write"}, 32'(pc_write), 32'd1);
                check({name, "_j_pc_source"}, 32'(pc_source), 32'd2);
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 4'b0110;
        zero   = 1'b0;
        stall  = 1'b0;

        repeat (5) @(posedge clock);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outputs", 32'({pc_write, ir_write, opcode_write, ab_write, alu_out_write,
                                  mem_read, mem_write, reg_write, mem_to_reg, alu_src_b,
                                  alu_op, pc_source, halted, illegal}), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);

        reset = 1'b1;
        #1;
        check("fetch_strobes", 32'({ir_write, opcode_write, mem_read, pc_write}), 32'hF);
        check("fetch_alu_src_b", 32'(alu_src_b), 32'd1);

        run_instr("jmp", 4'b0110, {12'd0, 4'd1, 4'd9, 4'd0}, 3);
        check("jmp_count", 32'(instr_count), 32'd1);
        run_instr("add", 4'b0001, {8'd0, 4'd1, 4'd2, 4'd7, 4'd0}, 4);
        check("add_count", 32'(instr_count), 32'd2);
        run_instr("lw", 4'b0011, {4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd0}, 5);
        check("lw_count", 32'(instr_count), 32'd3);
        run_instr("sw", 4'b0100, {8'd0, 4'd1, 4'd4, 4'd6, 4'd0}, 4);
        check("sw_count", 32'(instr_count), 32'd4);
        zero = 1'b0;
        run_instr("beq0", 4'b0101, {12'd0, 4'd1, 4'd8, 4'd0}, 3);
        zero = 1'b1;
        run_instr("beq1", 4'b0101, {12'd0, 4'd1, 4'd8, 4'd0}, 3);
        zero = 1'b0;
        check("beq_count", 32'(instr_count), 32'd6);

        opcode = 4'b1010;
        check("ill_fetch", 32'(illegal), 32'd0);
        tick();
        check("ill_decode_state", 32'(state), 32'd1);
        check("ill_pulse", 32'(illegal), 32'd1);
        tick();
        check("ill_back_state", 32'(state), 32'd0);
        check("ill_clear", 32'(illegal), 32'd0);
        check("ill_count", 32'(instr_count), 32'd6);

        opcode = 4'b0001;
        tick();
        tick();
        check("stl_exec", 32'(state), 32'd2);
        check("stl_aow_pre", 32'(alu_out_write), 32'd1);
        stall = 1'b1;
        #1;
        check("stl_aow_gated", 32'(alu_out_write), 32'd0);
        check("stl_alu_op", 32'(alu_op), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_hold", 32'(state), 32'd2);
            check("stl_aow", 32'(alu_out_write), 32'd0);
        end
        stall = 1'b0;
        #1;
        check("stl_aow_post", 32'(alu_out_write), 32'd1);
        tick();
        check("stl_wb", 32'(state), 32'd7);
        check("stl_wb_regw", 32'(reg_write), 32'd1);
        tick();
        check("stl_fetch", 32'(state), 32'd0);
        check("stl_count", 32'(instr_count), 32'd7);

        // Reset in the middle of an instruction, then wrap the counter with NOPs.
        opcode = 4'b0011;
        tick();
        tick();
        check("mid_state", 32'(state), 32'd4);
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_count", 32'(instr_count), 32'd0);
        check("mid_rst_aow", 32'(alu_out_write), 32'd0);
        tick();
        reset  = 1'b1;
        opcode = 4'b0000;
        for (int i = 0; i < 256; i++) begin
            tick();
            tick();
            if (i == 0) check("nop_first", 32'(instr_count), 32'd1);
            if (i == 254) check("nop_255", 32'(instr_count), 32'd255);
        end
        check("nop_wrap", 32'(instr_count), 32'd0);
        check("nop_state", 32'(state), 32'd0);

        opcode = 4'b1111;
        tick();
        check("halt_decode", 32'(state), 32'd1);
        tick();
        check("halt_state", 32'(state), 32'd10);
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            stall = (i % 2 == 0);
            tick();
            check("halt_hold", 32'(state), 32'd10);
            check("halt_hflag", 32'(halted), 32'd1);
            check("halt_pcw", 32'(pc_write), 32'd0);
        end
        stall = 1'b0;
        check("halt_count", 32'(instr_count), 32'd0);
        reset = 1'b0;
        #1;
        check("halt_rst_state", 32'(state), 32'd0);
        check("halt_rst_flag", 32'(halted), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("halt_rel_irw", 32'(ir_write), 32'd1);
        tick();
        check("halt_rel_decode", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
